icache_refill_controller: RTL and testbench

- Tag/valid store and miss-handling sequencer for the fully associative instruction cache data array.
- Sits between the fetch stage and the cache data array, with the next-level memory behind it.
- Compares the fetch address against all tags in parallel and drives the data array read/write controls.
- On a miss, fetches the block from memory, refills a victim line, then replays the read.

---
 rtl/icache_refill_controller.sv | 157 +++++++++++++++
 tb/tb_icache_refill_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_controller.sv
// Tag/valid store and miss sequencer for a fully associative instruction cache.
// Looks up the fetch tag against every line in parallel and drives the data array
// read and write strobes. On a miss it fetches the block from memory, writes it
// into a victim line, and then replays the read from that line.
module icache_refill_controller #(
  parameter int BLOCK_WIDTH = 512,
  parameter int LINES       = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int TAG_WIDTH   = 26
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic [ADDR_WIDTH-1:0]                  ADDR_IN,
  input  logic                                   ADDR_VALID,
  output logic                                   READY,
  output logic                                   HIT,
  output logic                                   RESP_VALID,
  input  logic                                   FLUSH,
  output logic                                   MEM_REQ,
  output logic [ADDR_WIDTH-1:0]                  MEM_ADDR,
  input  logic                                   MEM_ACK,
  input  logic [BLOCK_WIDTH-1:0]                 MEM_DATA,
  output logic [(LINES > 1 ? $clog2(LINES) : 1)-1:0] WRITE_TAG_ADDRESS,
  output logic [BLOCK_WIDTH-1:0]                 DATA_IN,
  output logic                                   WRITE_ENABLE,
  output logic [(LINES > 1 ? $clog2(LINES) : 1)-1:0] READ_TAG_ADDRESS,
  output logic                                   READ_ENBLE,
  output logic                                   READ_HIT
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int OFF_W = ADDR_WIDTH - TAG_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MISS_REQ = 2'd1,
    S_REPLAY   = 2'd2
  } state_t;

  state_t               state_q;
  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q [LINES];
  logic [IDX_W-1:0]     victim_ptr_q;
  logic [IDX_W-1:0]     victim_q;
  logic                 victim_was_valid_q;
  logic                 flush_pending_q;
  logic [TAG_WIDTH-1:0] miss_tag_q;
  logic                 resp_valid_q;

  logic [TAG_WIDTH-1:0] lookup_tag;
  logic [LINES-1:0]     match;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic                 flush_now;
  logic                 lookup_hit;
  logic                 lookup_miss;
  logic                 fill;
  logic [IDX_W-1:0]     victim_ptr_inc;
  logic                 unused_addr_bits;

  assign lookup_tag       = ADDR_IN[ADDR_WIDTH-1 -: TAG_WIDTH];
  // Offset bits select bytes inside the block and never take part in the lookup.
  assign unused_addr_bits = ^ADDR_IN[OFF_W-1:0];

  // Parallel tag compare, one comparator per line.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_match
      assign match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag);
    end
  endgenerate

  // Priority-encode the hit vector and the free-line vector; lowest index wins.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (match[i])   hit_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign hit_any  = |match;
  assign free_any = ~&valid_q;

  assign flush_now   = FLUSH | flush_pending_q;
  assign lookup_hit  = (state_q == S_IDLE) && !flush_now && ADDR_VALID && hit_any;
  assign lookup_miss = (state_q == S_IDLE) && !flush_now && ADDR_VALID && !hit_any;
  assign fill        = (state_q == S_MISS_REQ) && MEM_ACK;

  assign victim_ptr_inc = (victim_ptr_q == IDX_W'(LINES - 1)) ? '0 : victim_ptr_q + 1'b1;

  // Lookup and replay outputs follow the state and the inputs in the same cycle.
  assign READY             = (state_q == S_IDLE) && !flush_now;
  assign HIT               = lookup_hit;
  assign READ_ENBLE        = lookup_hit || (state_q == S_REPLAY);
  assign READ_HIT          = READ_ENBLE;
  assign READ_TAG_ADDRESS  = lookup_hit ? hit_idx :
                             (state_q == S_REPLAY) ? victim_q : '0;
  assign MEM_REQ           = (state_q == S_MISS_REQ);
  assign MEM_ADDR          = MEM_REQ ? {miss_tag_q, {OFF_W{1'b0}}} : '0;
  assign WRITE_ENABLE      = fill;
  assign WRITE_TAG_ADDRESS = fill ? victim_q : '0;
  assign DATA_IN           = fill ? MEM_DATA : '0;
  assign RESP_VALID        = resp_valid_q;

  // Sequencer: valid bits, victim choice, pending flush and the miss/replay FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q            <= S_IDLE;
      valid_q            <= '0;
      victim_ptr_q       <= '0;
      victim_q           <= '0;
      victim_was_valid_q <= 1'b0;
      flush_pending_q    <= 1'b0;
      miss_tag_q         <= '0;
      resp_valid_q       <= 1'b0;
    end else begin
      resp_valid_q <= READ_ENBLE;
      case (state_q)
        S_IDLE: begin
          if (flush_now) begin
            valid_q         <= '0;
            victim_ptr_q    <= '0;
            flush_pending_q <= 1'b0;
          end else if (lookup_miss) begin
            miss_tag_q         <= lookup_tag;
            victim_q           <= free_any ? free_idx : victim_ptr_q;
            victim_was_valid_q <= !free_any;
            state_q            <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (FLUSH) flush_pending_q <= 1'b1;
          if (MEM_ACK) begin
            valid_q[victim_q] <= 1'b1;
            // Round-robin only advances when a live line was displaced.
            if (victim_was_valid_q) victim_ptr_q <= victim_ptr_inc;
            state_q <= S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (FLUSH) flush_pending_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag store; tags are meaningless until their valid bit is set, so no reset.
  always_ff @(posedge CLK) begin
    if (fill) tag_q[victim_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Self-checking bench for icache_refill_controller (4-line configuration).
// A behavioural data array sits on the write/read ports; refill data comes from
// an address-derived pattern, and each expected response is queued when the
// access is driven and compared when RESP_VALID shows up.
module tb_icache_refill_controller;

  localparam int BW    = 512;
  localparam int LINES = 4;
  localparam int AW    = 32;
  localparam int IDX_W = 2;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [AW-1:0]   ADDR_IN;
  logic            ADDR_VALID;
  logic            READY;
  logic            HIT;
  logic            RESP_VALID;
  logic            FLUSH;
  logic            MEM_REQ;
  logic [AW-1:0]   MEM_ADDR;
  logic            MEM_ACK;
  logic [BW-1:0]   MEM_DATA;
  logic [IDX_W-1:0] WRITE_TAG_ADDRESS;
  logic [BW-1:0]   DATA_IN;
  logic            WRITE_ENABLE;
  logic [IDX_W-1:0] READ_TAG_ADDRESS;
  logic            READ_ENBLE;
  logic            READ_HIT;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BW-1:0] sb_q [$];
  logic [BW-1:0] arr [LINES];
  logic [BW-1:0] rd_data;

  icache_refill_controller #(
    .BLOCK_WIDTH(BW), .LINES(LINES), .ADDR_WIDTH(AW), .TAG_WIDTH(26)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ADDR_IN(ADDR_IN), .ADDR_VALID(ADDR_VALID),
    .READY(READY), .HIT(HIT), .RESP_VALID(RESP_VALID), .FLUSH(FLUSH),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .WRITE_TAG_ADDRESS(WRITE_TAG_ADDRESS), .DATA_IN(DATA_IN), .WRITE_ENABLE(WRITE_ENABLE),
    .READ_TAG_ADDRESS(READ_TAG_ADDRESS), .READ_ENBLE(READ_ENBLE), .READ_HIT(READ_HIT)
  );

  always #5 CLK = ~CLK;

  // Data array stand-in: registered read, write port fed by the controller.
  always @(posedge CLK) begin
    if (WRITE_ENABLE) arr[WRITE_TAG_ADDRESS] <= DATA_IN;
    if (READ_ENBLE)   rd_data <= arr[READ_TAG_ADDRESS];
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
    logic [BW-1:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = {a[31:6], 6'(i)} ^ 32'hA5A5_5A5A;
    return p;
  endfunction

  // Scoreboard pop: every response must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST_N && RESP_VALID) begin
      if (sb_q.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp_data", rd_data, sb_q.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; ADDR_VALID = 1'b0; FLUSH = 1'b0; MEM_ACK = 1'b0; MEM_DATA = '0; ADDR_IN = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic do_hit(input logic [AW-1:0] a, input int line);
    @(negedge CLK);
    ADDR_IN = a; ADDR_VALID = 1'b1; MEM_ACK = 1'b1; MEM_DATA = '1;
    #1;
    $display("hit  addr=%08h line=%0d", a, line);
    check("hit_hit", HIT, 1);
    check("hit_ready", READY, 1);
    check("hit_rd_en", READ_ENBLE, 1);
    check("hit_rd_hit", READ_HIT, 1);
    check("hit_rd_idx", READ_TAG_ADDRESS, line);
    check("hit_memreq", MEM_REQ, 0);
    check("hit_ack_ignored", WRITE_ENABLE, 0);
    sb_q.push_back(pattern(a));
    @(posedge CLK);
    @(negedge CLK);
    ADDR_VALID = 1'b0; MEM_ACK = 1'b0; MEM_DATA = '0;
    #1;
    check("hit_resp_valid", RESP_VALID, 1);
    check("hit_memreq_after", MEM_REQ, 0);
  endtask

  task automatic do_miss(input logic [AW-1:0] a, input int victim, input int ack_delay, input bit flush_pulse);
    @(negedge CLK);
    ADDR_IN = a; ADDR_VALID = 1'b1;
    #1;
    $display("miss addr=%08h victim=%0d delay=%0d flush=%0d", a, victim, ack_delay, flush_pulse);
    check("miss_hit", HIT, 0);
    check("miss_ready", READY, 1);
    check("miss_memreq_early", MEM_REQ, 0);
    @(posedge CLK);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge CLK);
      ADDR_VALID = 1'b0;
      FLUSH = flush_pulse && (i == 0);
      #1;
      check("req_memreq", MEM_REQ, 1);
      check("req_memaddr", MEM_ADDR, a & 32'hFFFF_FFC0);
      check("req_ready", READY, 0);
      check("req_we", WRITE_ENABLE, 0);
      @(posedge CLK);
    end
    @(negedge CLK);
    FLUSH = 1'b0; ADDR_VALID = 1'b0; MEM_ACK = 1'b1; MEM_DATA = pattern(a);
    #1;
    check("ack_we", WRITE_ENABLE, 1);
    check("ack_widx", WRITE_TAG_ADDRESS, victim);
    check("ack_data", DATA_IN, pattern(a));
    check("ack_memreq", MEM_REQ, 1);
    check("ack_no_rd", READ_ENBLE, 0);
    sb_q.push_back(pattern(a));
    @(posedge CLK);
    @(negedge CLK);
    MEM_ACK = 1'b0; MEM_DATA = '0;
    #1;
    check("rep_memreq", MEM_REQ, 0);
    check("rep_rd_en", READ_ENBLE, 1);
    check("rep_rd_hit", READ_HIT, 1);
    check("rep_rd_idx", READ_TAG_ADDRESS, victim);
    check("rep_we", WRITE_ENABLE, 0);
    check("rep_data_zero", DATA_IN, 0);
    check("rep_ready", READY, 0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rep_resp_valid", RESP_VALID, 1);
    check("idle_ready", READY, !flush_pulse);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; ADDR_VALID = 1'b0; FLUSH = 1'b0; MEM_ACK = 1'b0; MEM_DATA = '0; ADDR_IN = '0;
    do_reset();
    #1;
    $display("reset state");
    check("rst_memreq", MEM_REQ, 0);
    check("rst_we", WRITE_ENABLE, 0);
    check("rst_rd_en", READ_ENBLE, 0);
    check("rst_rd_hit", READ_HIT, 0);
    check("rst_hit", HIT, 0);
    check("rst_resp", RESP_VALID, 0);
    check("rst_ready", READY, 1);
    check("rst_ridx", READ_TAG_ADDRESS, 0);
    check("rst_widx", WRITE_TAG_ADDRESS, 0);
    check("rst_data_in", DATA_IN, 0);

    // Cold miss, then a hit elsewhere in the same block.
    do_miss(32'h0000_1040, 0, 3, 1'b0);
    do_hit(32'h0000_1078, 0);

    // Fill all four lines, then exercise round-robin replacement.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_miss(32'(i * 64), i, 1 + (i % 2), 1'b0);
      do_hit(32'(i * 64), i);
    end
    do_miss(32'h100, 0, 1, 1'b0);
    do_hit(32'h100, 0);
    do_miss(32'h140, 1, 2, 1'b0);
    do_hit(32'h140, 1);
    do_hit(32'h080, 2);
    do_miss(32'h000, 2, 1, 1'b0);
    do_hit(32'h000, 2);
    do_miss(32'h040, 3, 1, 1'b0);
    do_hit(32'h040, 3);

    // Flush in IDLE with every line valid.
    @(negedge CLK);
    FLUSH = 1'b1; ADDR_IN = 32'h040; ADDR_VALID = 1'b1;
    #1;
    $display("flush idle");
    check("flush_ready", READY, 0);
    check("flush_no_hit", HIT, 0);
    check("flush_no_rd", READ_ENBLE, 0);
    @(posedge CLK);
    @(negedge CLK);
    FLUSH = 1'b0; ADDR_VALID = 1'b0;
    do_miss(32'h040, 0, 2, 1'b0);
    do_hit(32'h040, 0);

    // Flush arriving mid-miss is deferred until after the replay.
    do_miss(32'h080, 1, 2, 1'b1);
    do_miss(32'h080, 0, 1, 1'b0);
    do_hit(32'h080, 0);

    // Reset while a fetch is outstanding.
    @(negedge CLK);
    ADDR_IN = 32'h200; ADDR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ADDR_VALID = 1'b0;
    #1;
    $display("reset mid-miss");
    check("mid_memreq_before", MEM_REQ, 1);
    #1 RST_N = 1'b0;
    #1;
    check("mid_memreq_async", MEM_REQ, 0);
    MEM_ACK = 1'b1; MEM_DATA = pattern(32'h200);
    #1;
    check("mid_no_we", WRITE_ENABLE, 0);
    @(posedge CLK);
    @(negedge CLK);
    MEM_ACK = 1'b0; MEM_DATA = '0; RST_N = 1'b1;
    do_miss(32'h080, 0, 1, 1'b0);
    do_hit(32'h080, 0);

    repeat (2) @(negedge CLK);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
